pipeline_hazard_unit: RTL and testbench

Stall and flush controller for the 5-stage pipeline, and the producer-side counterpart to the EX-stage forwarding logic. It keeps a shadow scoreboard of destination registers in flight in EX, MEM and WB. It detects the one hazard forwarding cannot cover, the load-use hazard, and resolves it by holding IF/ID and inserting a bubble into ID/EX. It also squashes wrong-path instructions on a taken branch, freezes the whole pipeline while data memory is busy, and keeps saturating stall and flush counters.

---
 rtl/pipeline_hazard_unit_pkg.sv | 31 +++
 rtl/pipeline_hazard_unit_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_unit.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared pipeline definitions: register address width, NOP encoding,
// the shadow-stage tag and the hazard action encoding.
package pipeline_hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } stage_tag_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_STALL,
        ACT_RUN
    } hazard_act_t;

    // One-hot destination bit for a shadow stage, zero when it writes nothing or x0.
    function automatic logic [31:0] stage_mask(input stage_tag_t s);
        logic [31:0] m;
        m = '0;
        m[s.rd] = s.valid & s.reg_write & (s.rd != '0);
        return m;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Saturating up-counter with a freeze input; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         hold,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !hold && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller: shadow scoreboard of EX/MEM/WB destinations,
// load-use detection, branch squash, memory-busy freeze and perf counters.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_busy,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  load_use_stall,
    output logic [31:0]           pending_mask,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    stage_tag_t  ex_q, mem_q, wb_q;
    stage_tag_t  ex_d;
    hazard_act_t act;
    logic        lu;

    always_comb begin
        lu = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != '0) & id_valid &
             ((id_rs1_used & (id_rs1 == ex_q.rd)) | (id_rs2_used & (id_rs2 == ex_q.rd)));
    end

    // Outputs are forced quiet while reset is asserted, not just on the next edge.
    always_comb begin
        act = ACT_RUN;
        if (!rst_n) begin
            act = ACT_RESET;
        end else if (dmem_busy) begin
            act = ACT_FREEZE;
        end else if (ex_branch_taken) begin
            act = ACT_FLUSH;
        end else if (lu) begin
            act = ACT_STALL;
        end
    end

    always_comb begin
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        idex_en        = 1'b0;
        exmem_en       = 1'b0;
        memwb_en       = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        load_use_stall = 1'b0;
        unique case (act)
            ACT_RESET, ACT_FREEZE: begin
            end
            ACT_FLUSH: begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                idex_en     = 1'b1;
                exmem_en    = 1'b1;
                memwb_en    = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ACT_STALL: begin
                idex_en        = 1'b1;
                exmem_en       = 1'b1;
                memwb_en       = 1'b1;
                idex_bubble    = 1'b1;
                load_use_stall = 1'b1;
            end
            default: begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        endcase
    end

    always_comb begin
        ex_d = '0;
        if (!idex_bubble) begin
            ex_d.valid     = id_valid;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!dmem_busy) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_comb begin
        pending_mask = stage_mask(ex_q) | stage_mask(mem_q) | stage_mask(wb_q);
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_use_stall),
        .hold  (dmem_busy),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifid_flush),
        .hold  (dmem_busy),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit with a 4-bit counter build.
module tb_pipeline_hazard_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0, dmem_busy = 1'b0;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_bubble, load_use_stall;
    logic [31:0]   pending_mask;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [4:0]    en;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   exp_stall = 0;
    int unsigned   exp_flush = 0;

    always #5 clk = ~clk;

    assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};

    pipeline_hazard_unit #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_busy       (dmem_busy),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .load_use_stall  (load_use_stall),
        .pending_mask    (pending_mask),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic set_lw5();  set_id(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1); endtask
    task automatic set_add65(); set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0); endtask

    task automatic bump_stall();
        if (exp_stall != 15) exp_stall++;
    endtask

    task automatic drain();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
        dmem_busy = 0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (en !== 5'b00000 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl actual en=%b fl=%b bub=%b lu=%b required all 0", en, ifid_flush, idex_bubble, load_use_stall);
        end
        checks++;
        if (pending_mask !== 32'h0 || stall_cycles !== '0 || flush_count !== '0) begin
            errors++;
            $display("FAIL reset_state actual mask=%h st=%0d fc=%0d required 0", pending_mask, stall_cycles, flush_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if (en !== 5'b11111 || idex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_release actual en=%b bub=%b required 11111 0", en, idex_bubble);
        end
    endtask

    task automatic test_load_use_rs1();
        set_lw5(); #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_first_load actual lu=%b required 0", load_use_stall);
        end
        cyc();
        set_add65(); #1;
        checks++;
        if (en !== 5'b00111 || idex_bubble !== 1'b1 || load_use_stall !== 1'b1 || ifid_flush !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall actual en=%b bub=%b lu=%b fl=%b required 00111 1 1 0", en, idex_bubble, load_use_stall, ifid_flush);
        end
        checks++;
        if (pending_mask !== 32'h0000_0020) begin
            errors++;
            $display("FAIL lu_mask actual %h required 00000020", pending_mask);
        end
        cyc();
        bump_stall();
        checks++;
        if (en !== 5'b11111 || idex_bubble !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_after actual en=%b bub=%b lu=%b required 11111 0 0", en, idex_bubble, load_use_stall);
        end
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL lu_count actual %0d required %0d", stall_cycles, exp_stall);
        end
        drain();
    endtask

    task automatic test_no_stall();
        set_id(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1); #1;
        cyc();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0); #1;
        checks++;
        if (load_use_stall !== 1'b0 || en !== 5'b11111 || pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL x0_load actual lu=%b en=%b mask=%h required 0 11111 0", load_use_stall, en, pending_mask);
        end
        cyc();
        set_lw5(); #1;
        cyc();
        set_id(1, 5'd5, 0, 5'd5, 0, 5'd5, 1, 0); #1;
        checks++;
        if (load_use_stall !== 1'b0 || idex_bubble !== 1'b0) begin
            errors++;
            $display("FAIL unused_rs actual lu=%b bub=%b required 0 0", load_use_stall, idex_bubble);
        end
        cyc();
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL no_stall_count actual %0d required %0d", stall_cycles, exp_stall);
        end
        drain();
    endtask

    task automatic test_branch_lu();
        set_lw5(); #1;
        cyc();
        set_add65(); ex_branch_taken = 1; #1;
        checks++;
        if (en !== 5'b11111 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL br_lu actual en=%b fl=%b bub=%b lu=%b required 11111 1 1 0", en, ifid_flush, idex_bubble, load_use_stall);
        end
        cyc();
        exp_flush++;
        ex_branch_taken = 0;
        checks++;
        if (flush_count !== CW'(exp_flush) || stall_cycles !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL br_counts actual fc=%0d st=%0d required %0d %0d", flush_count, stall_cycles, exp_flush, exp_stall);
        end
        drain();
    endtask

    task automatic test_dmem_busy();
        set_lw5(); #1;
        cyc();
        set_add65(); dmem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (en !== 5'b00000 || idex_bubble !== 1'b0 || load_use_stall !== 1'b0 || pending_mask !== 32'h0000_0020) begin
                errors++;
                $display("FAIL busy_freeze%0d actual en=%b bub=%b lu=%b mask=%h required 00000 0 0 00000020", i, en, idex_bubble, load_use_stall, pending_mask);
            end
            cyc();
        end
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL busy_count actual %0d required %0d", stall_cycles, exp_stall);
        end
        dmem_busy = 0; #1;
        checks++;
        if (en !== 5'b00111 || load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL busy_release actual en=%b lu=%b required 00111 1", en, load_use_stall);
        end
        cyc();
        bump_stall();
        checks++;
        if (stall_cycles !== CW'(exp_stall)) begin
            errors++;
            $display("FAIL busy_stall_count actual %0d required %0d", stall_cycles, exp_stall);
        end
        drain();
    endtask

    task automatic test_pending_mask();
        logic [31:0] exp_m [6];
        exp_m[0] = 32'h0000_0008; exp_m[1] = 32'h0000_0088; exp_m[2] = 32'h0000_0288;
        exp_m[3] = 32'h0000_0280; exp_m[4] = 32'h0000_0200; exp_m[5] = 32'h0000_0000;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_id(1, 5'd0, 1, 5'd0, 0, 5'd3, 1, 0);
                1: set_id(1, 5'd0, 1, 5'd0, 0, 5'd7, 1, 0);
                2: set_id(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 0);
                default: set_id(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            #1;
            cyc();
            checks++;
            if (pending_mask !== exp_m[i]) begin
                errors++;
                $display("FAIL mask_step%0d actual %h required %h", i, pending_mask, exp_m[i]);
            end
        end
    endtask

    task automatic test_saturation_reset();
        for (int p = 0; p < 20; p++) begin
            set_lw5(); #1;
            cyc();
            set_add65(); #1;
            cyc();
            bump_stall();
            cyc();
        end
        checks++;
        if (stall_cycles !== 4'd15 || exp_stall != 15) begin
            errors++;
            $display("FAIL saturate actual %0d required 15", stall_cycles);
        end
        checks++;
        if (flush_count !== CW'(exp_flush)) begin
            errors++;
            $display("FAIL flush_hold actual %0d required %0d", flush_count, exp_flush);
        end
        set_lw5(); #1;
        cyc();
        set_add65(); #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall actual %b required 1", load_use_stall);
        end
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checks++;
        if (stall_cycles !== '0 || flush_count !== '0 || pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL midstall_reset actual st=%0d fc=%0d mask=%h required 0 0 0", stall_cycles, flush_count, pending_mask);
        end
        checks++;
        if (en !== 5'b00000 || idex_bubble !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL midstall_ctrl actual en=%b bub=%b lu=%b required 00000 0 0", en, idex_bubble, load_use_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (en !== 5'b11111 || idex_bubble !== 1'b0 || load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL no_residual actual en=%b bub=%b lu=%b required 11111 0 0", en, idex_bubble, load_use_stall);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        drain();
        test_load_use_rs1();
        test_no_stall();
        test_branch_lu();
        test_dmem_busy();
        test_pending_mask();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
